// File: rtl/galvo_scan_ctrl_pkg.sv
// Shared constants for the galvo scan controller: DAC frame layout, address codes,
// controller state encoding and the frame builder.
package galvo_scan_ctrl_pkg;

  localparam int FRAME_W = 24;
  localparam int POS_W   = 11;

  typedef logic [POS_W-1:0]   pos_t;
  typedef logic [FRAME_W-1:0] frame_t;

  localparam logic [3:0] DAC_CMD = 4'h3;
  localparam logic [3:0] ADDR_H  = 4'h0;
  localparam logic [3:0] ADDR_V  = 4'h1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // DAC word: command, channel address, 11-bit position left-justified in a 16-bit field
  function automatic frame_t build_frame(input logic [3:0] addr, input pos_t pos);
    return {DAC_CMD, addr, pos, 5'b0_0000};
  endfunction

endpackage

// File: rtl/galvo_scan_ctrl_if.sv
// DAC SPI bus bundle; the scan controller drives it through the master modport.
interface galvo_scan_ctrl_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_csn;

  modport master (output spi_sclk, output spi_mosi, output spi_csn);
  modport slave  (input  spi_sclk, input  spi_mosi, input  spi_csn);
endinterface

// File: rtl/galvo_scan_ctrl_spi_shift.sv
// Mode-0 MSB-first 24-bit SPI shifter with clock divider and chip-select timing.
// done_o is high in the last cycle of the final bit, the cycle before csn rises.
module galvo_spi_shift
  import galvo_scan_ctrl_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   start_i,
  input  frame_t frame_i,
  output logic   busy_o,
  output logic   done_o,
  output logic   sclk_o,
  output logic   mosi_o,
  output logic   csn_o
);

  localparam int            DW       = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] HALF_M1  = DW'(SCLK_DIV / 2 - 1);
  localparam logic [4:0]    BIT_LAST = 5'(FRAME_W - 1);

  frame_t        sh_q, sh_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic          busy_q, busy_d, sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d;
  logic          bit_end_s, last_s;

  // Next-state logic for shift register, divider, bit counter and bus pins
  always_comb begin
    bit_end_s = busy_q && (div_q == DIV_LAST);
    last_s    = bit_end_s && (bit_q == BIT_LAST);
    sh_d   = sh_q;
    div_d  = div_q;
    bit_d  = bit_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    csn_d  = csn_q;
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      csn_d  = 1'b0;
      sh_d   = frame_i;
      mosi_d = frame_i[FRAME_W-1];
      div_d  = {DW{1'b0}};
      bit_d  = 5'd0;
      sclk_d = 1'b0;
    end else if (last_s) begin
      busy_d = 1'b0;
      csn_d  = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      div_d  = {DW{1'b0}};
      bit_d  = 5'd0;
    end else if (bit_end_s) begin
      // sclk falls and the next bit is presented on the same edge
      div_d  = {DW{1'b0}};
      bit_d  = bit_q + 5'd1;
      sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
      mosi_d = sh_q[FRAME_W-2];
      sclk_d = 1'b0;
    end else if (busy_q) begin
      div_d  = div_q + {{(DW-1){1'b0}}, 1'b1};
      sclk_d = (div_q >= HALF_M1);
    end else begin
      busy_d = 1'b0;
    end
  end

  // Shifter state registers; reset aborts any frame with csn high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q   <= {FRAME_W{1'b0}};
      div_q  <= {DW{1'b0}};
      bit_q  <= 5'd0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      csn_q  <= 1'b1;
    end else begin
      sh_q   <= sh_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      csn_q  <= csn_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_s;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign csn_o  = csn_q;

endmodule

// File: rtl/galvo_scan_ctrl.sv
// Galvo raster scan position sequencer with DAC SPI update per step.
// Define GALVO_SERPENTINE_EN for bidirectional (serpentine) horizontal scanning.
module galvo_scan_ctrl
  import galvo_scan_ctrl_pkg::*;
#(
  parameter int H_PIXELS = 1024,
  parameter int V_LINES  = 1024,
  parameter int SCLK_DIV = 4
) (
  input  logic                clk_adc,
  input  logic                rst_adc_n,
  input  logic                galvo_go,
  input  logic                scan_home,
  output logic [10:0]         galvoh,
  output logic [10:0]         galvov,
  output logic                galvo_spi_done,
  output logic                frame_end,
  output logic                overrun,
  galvo_scan_ctrl_if.master   spi
);

  localparam pos_t H_LAST = POS_W'(H_PIXELS - 1);
  localparam pos_t V_LAST = POS_W'(V_LINES - 1);

  logic [2:0] state_q, state_d;
  pos_t       h_q, h_d, v_q, v_d;
  logic       send_v_q, send_v_d, addr_v_q, addr_v_d;
  logic       home_pend_q, home_pend_d, overrun_q, overrun_d;
  logic       done_q, done_d, frame_end_q, frame_end_d;
  logic       line_end_s, start_s, sp_busy_s, sp_done_s;
  frame_t     frame_s;
`ifdef GALVO_SERPENTINE_EN
  logic       dir_q, dir_d;
`endif

  // Controller FSM, position stepping, overrun and deferred-home bookkeeping
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    send_v_d    = send_v_q;
    addr_v_d    = addr_v_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    frame_end_d = 1'b0;
    start_s     = 1'b0;
    frame_s     = build_frame(addr_v_q ? ADDR_V : ADDR_H, addr_v_q ? v_q : h_q);
`ifdef GALVO_SERPENTINE_EN
    dir_d       = dir_q;
    line_end_s  = dir_q ? (h_q == 11'd0) : (h_q == H_LAST);
`else
    line_end_s  = (h_q == H_LAST);
`endif
    if (state_q != ST_IDLE) begin
      home_pend_d = home_pend_q | scan_home;
      overrun_d   = overrun_q | galvo_go;
    end else begin
      home_pend_d = home_pend_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (scan_home || home_pend_q) begin
          h_d         = 11'd0;
          v_d         = 11'd0;
          overrun_d   = 1'b0;
          home_pend_d = 1'b0;
          send_v_d    = 1'b1;
          addr_v_d    = 1'b0;
          state_d     = ST_LOAD;
`ifdef GALVO_SERPENTINE_EN
          dir_d       = 1'b0;
`endif
        end else if (galvo_go) begin
          addr_v_d = 1'b0;
          send_v_d = line_end_s;
          state_d  = ST_LOAD;
          if (!line_end_s) begin
`ifdef GALVO_SERPENTINE_EN
            h_d = dir_q ? (h_q - 11'd1) : (h_q + 11'd1);
`else
            h_d = h_q + 11'd1;
`endif
          end else if (v_q == V_LAST) begin
            h_d         = 11'd0;
            v_d         = 11'd0;
            frame_end_d = 1'b1;
`ifdef GALVO_SERPENTINE_EN
            dir_d       = 1'b0;
`endif
          end else begin
            v_d = v_q + 11'd1;
`ifdef GALVO_SERPENTINE_EN
            dir_d = ~dir_q;
`else
            h_d = 11'd0;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        start_s = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A pending home abandons the rest of this update and suppresses its done pulse
        if (sp_done_s) begin
          if (home_pend_d) begin
            state_d = ST_IDLE;
          end else if (send_v_q && !addr_v_q) begin
            addr_v_d = 1'b1;
            state_d  = ST_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end else if (!sp_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        state_d = ST_LOAD;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      state_q     <= ST_IDLE;
      h_q         <= 11'd0;
      v_q         <= 11'd0;
      send_v_q    <= 1'b0;
      addr_v_q    <= 1'b0;
      home_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      send_v_q    <= send_v_d;
      addr_v_q    <= addr_v_d;
      home_pend_q <= home_pend_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      frame_end_q <= frame_end_d;
    end
  end

`ifdef GALVO_SERPENTINE_EN
  // Scan direction: 0 = increasing galvoh
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  galvo_spi_shift #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk_i   (clk_adc),
    .rst_ni  (rst_adc_n),
    .start_i (start_s),
    .frame_i (frame_s),
    .busy_o  (sp_busy_s),
    .done_o  (sp_done_s),
    .sclk_o  (spi.spi_sclk),
    .mosi_o  (spi.spi_mosi),
    .csn_o   (spi.spi_csn)
  );

  assign galvoh         = h_q;
  assign galvov         = v_q;
  assign galvo_spi_done = done_q;
  assign frame_end      = frame_end_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_galvo_scan_ctrl.sv
// Self-checking bench for galvo_scan_ctrl: directed scan sequences plus randomized
// go/home traffic checked against a step-count position model and an SPI bus monitor.
module tb_galvo_scan_ctrl;

`ifdef GALVO_SERPENTINE_EN
  localparam int HP = 3;
  localparam int NSEQ = 6;
  int tbl_h [8] = '{1, 2, 2, 1, 0, 0, 0, 0};
  int tbl_v [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
  localparam bit SERP = 1'b1;
`else
  localparam int HP = 4;
  localparam int NSEQ = 8;
  int tbl_h [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int tbl_v [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  localparam bit SERP = 1'b0;
`endif
  localparam int VL = 2;
  localparam int NPOS = HP * VL;

  logic        clk_adc = 1'b0;
  logic        rst_adc_n, galvo_go, scan_home;
  logic [10:0] galvoh, galvov;
  logic        galvo_spi_done, frame_end, overrun;

  galvo_scan_ctrl_if spi_if ();

  galvo_scan_ctrl #(.H_PIXELS(HP), .V_LINES(VL), .SCLK_DIV(4)) dut (
    .clk_adc        (clk_adc),
    .rst_adc_n      (rst_adc_n),
    .galvo_go       (galvo_go),
    .scan_home      (scan_home),
    .galvoh         (galvoh),
    .galvov         (galvov),
    .galvo_spi_done (galvo_spi_done),
    .frame_end      (frame_end),
    .overrun        (overrun),
    .spi            (spi_if)
  );

  always #5 clk_adc = ~clk_adc;

  int checks = 0;
  int errors = 0;

  // SPI bus monitor: frames captured at sclk rises, csn low/high run lengths, done delay
  logic [23:0] fr_q [$];
  int          len_q [$], nb_q [$], hi_q [$], dly_q [$];
  logic        prev_sclk = 1'b0, prev_csn = 1'b1;
  logic [23:0] mon_sh = 24'd0;
  int          mon_nb = 0, low_run = 0, high_run = 0, cyc = 0, rise_cyc = 0;

  always @(negedge clk_adc) begin
    cyc       <= cyc + 1;
    prev_sclk <= spi_if.spi_sclk;
    prev_csn  <= spi_if.spi_csn;
    if (spi_if.spi_csn == 1'b0) begin
      low_run <= low_run + 1;
      if (prev_csn) begin
        hi_q.push_back(high_run);
        mon_sh  <= 24'd0;
        mon_nb  <= 0;
        low_run <= 1;
      end else if (spi_if.spi_sclk && !prev_sclk) begin
        mon_sh <= {mon_sh[22:0], spi_if.spi_mosi};
        mon_nb <= mon_nb + 1;
      end
    end else begin
      high_run <= prev_csn ? high_run + 1 : 1;
      if (!prev_csn) begin
        fr_q.push_back(mon_sh);
        len_q.push_back(low_run);
        nb_q.push_back(mon_nb);
        rise_cyc <= cyc;
      end
    end
    if (galvo_spi_done) dly_q.push_back(cyc - rise_cyc);
  end

  // Reference model: positions are a pure function of steps taken since origin
  int mk = 0;
  int s_fr, s_hi, s_dly;
  logic obs_fe;

  function automatic int model_v(input int k);
    return k / HP;
  endfunction

  function automatic int model_h(input int k);
    int p;
    p = k % HP;
    if (SERP && ((k / HP) % 2 == 1)) return HP - 1 - p;
    return p;
  endfunction

  function automatic logic [23:0] mkframe(input int addr, input int pos);
    return {4'h3, 4'(addr), 11'(pos), 5'b00000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_fr  = fr_q.size();
    s_hi  = hi_q.size();
    s_dly = dly_q.size();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (galvo_spi_done !== 1'b1 && n < 1500) begin
      @(negedge clk_adc);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 1500), 32'd1);
    repeat (3) @(negedge clk_adc);
    #1;
  endtask

  task automatic check_txn(input string tag, input int nexp, input logic [23:0] f0, input logic [23:0] f1);
    chk({tag, "_nframes"}, 32'(fr_q.size() - s_fr), 32'(nexp));
    chk({tag, "_ndone"}, 32'(dly_q.size() - s_dly), 32'd1);
    if (dly_q.size() > s_dly) chk({tag, "_done_dly"}, 32'(dly_q[dly_q.size() - 1]), 32'd1);
    if (fr_q.size() - s_fr >= 1) begin
      chk({tag, "_frame0"}, 32'(fr_q[s_fr]), 32'(f0));
      chk({tag, "_csn_low0"}, 32'(len_q[s_fr]), 32'd96);
      chk({tag, "_nbits0"}, 32'(nb_q[s_fr]), 32'd24);
    end
    if (nexp == 2 && fr_q.size() - s_fr >= 2 && hi_q.size() - s_hi >= 2) begin
      chk({tag, "_frame1"}, 32'(fr_q[s_fr + 1]), 32'(f1));
      chk({tag, "_csn_low1"}, 32'(len_q[s_fr + 1]), 32'd96);
      chk({tag, "_gap"}, 32'(hi_q[s_hi + 1]), 32'd2);
    end
  endtask

  task automatic go_step(input string tag);
    int vchg;
    snap();
    @(negedge clk_adc); galvo_go = 1'b1;
    @(negedge clk_adc); galvo_go = 1'b0;
    mk   = (mk + 1) % NPOS;
    vchg = (mk % HP == 0) ? 1 : 0;
    obs_fe = frame_end;
    chk({tag, "_h"}, 32'(galvoh), 32'(model_h(mk)));
    chk({tag, "_v"}, 32'(galvov), 32'(model_v(mk)));
    chk({tag, "_fe"}, 32'(frame_end), 32'(mk == 0));
    wait_done(tag);
    check_txn(tag, vchg ? 2 : 1, mkframe(0, model_h(mk)), mkframe(1, model_v(mk)));
  endtask

  task automatic home_step(input string tag);
    snap();
    @(negedge clk_adc); scan_home = 1'b1;
    @(negedge clk_adc); scan_home = 1'b0;
    mk = 0;
    chk({tag, "_h"}, 32'(galvoh), 32'd0);
    chk({tag, "_v"}, 32'(galvov), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    wait_done(tag);
    check_txn(tag, 2, mkframe(0, 0), mkframe(1, 0));
  endtask

  initial begin
    logic [23:0] hf;
    int n;
    rst_adc_n = 1'b0;
    galvo_go  = 1'b0;
    scan_home = 1'b0;
    repeat (3) @(negedge clk_adc);
    chk("rst_h", 32'(galvoh), 32'd0);
    chk("rst_v", 32'(galvov), 32'd0);
    chk("rst_csn", 32'(spi_if.spi_csn), 32'd1);
    chk("rst_sclk", 32'(spi_if.spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_if.spi_mosi), 32'd0);
    chk("rst_done", 32'(galvo_spi_done), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_adc_n = 1'b1;
    repeat (2) @(negedge clk_adc);

    // Directed scan sequence from reset; first step carries the well-known first frame
    for (int i = 0; i < NSEQ; i++) begin
      go_step("seq");
      if (i == 0) chk("first_frame", 32'(fr_q[s_fr]), 32'h0030_0020);
      chk("seq_tbl_h", 32'(galvoh), 32'(tbl_h[i]));
      chk("seq_tbl_v", 32'(galvov), 32'(tbl_v[i]));
      chk("seq_tbl_fe", 32'(obs_fe), 32'(i == NSEQ - 1));
      repeat (20) @(negedge clk_adc);
    end

    // Second go while busy is dropped and flagged
    snap();
    @(negedge clk_adc); galvo_go = 1'b1;
    @(negedge clk_adc); galvo_go = 1'b0;
    mk = (mk + 1) % NPOS;
    repeat (8) @(negedge clk_adc);
    galvo_go = 1'b1;
    @(negedge clk_adc); galvo_go = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_h_once", 32'(galvoh), 32'(model_h(mk)));
    chk("ovr_v_once", 32'(galvov), 32'(model_v(mk)));
    wait_done("ovr");
    check_txn("ovr", (mk % HP == 0) ? 2 : 1, mkframe(0, model_h(mk)), mkframe(1, model_v(mk)));
    chk("ovr_sticky", 32'(overrun), 32'd1);
    home_step("home_idle");

    // Home arriving mid-update: update finishes its current frame, no done for it
    go_step("pre");
    snap();
    @(negedge clk_adc); galvo_go = 1'b1;
    @(negedge clk_adc); galvo_go = 1'b0;
    mk = (mk + 1) % NPOS;
    hf = mkframe(0, model_h(mk));
    repeat (29) @(negedge clk_adc);
    scan_home = 1'b1;
    @(negedge clk_adc); scan_home = 1'b0;
    mk = 0;
    wait_done("hbusy");
    chk("hbusy_nframes", 32'(fr_q.size() - s_fr), 32'd3);
    chk("hbusy_ndone", 32'(dly_q.size() - s_dly), 32'd1);
    if (fr_q.size() - s_fr == 3) begin
      chk("hbusy_f0", 32'(fr_q[s_fr]), 32'(hf));
      chk("hbusy_f1", 32'(fr_q[s_fr + 1]), 32'(mkframe(0, 0)));
      chk("hbusy_f2", 32'(fr_q[s_fr + 2]), 32'(mkframe(1, 0)));
    end
    chk("hbusy_h", 32'(galvoh), 32'd0);
    chk("hbusy_v", 32'(galvov), 32'd0);

    // Randomized go/home traffic
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 9) < 8) go_step("rnd_go");
      else home_step("rnd_home");
      repeat ($urandom_range(1, 40)) @(negedge clk_adc);
    end

    // Asynchronous reset in the middle of a frame
    @(negedge clk_adc); galvo_go = 1'b1;
    @(negedge clk_adc); galvo_go = 1'b0;
    n = 0;
    #1;
    while (!(spi_if.spi_csn == 1'b0 && mon_nb >= 12) && n < 400) begin
      @(negedge clk_adc); #1;
      n++;
    end
    chk("mid_rst_reach_bit12", 32'(n < 400), 32'd1);
    #1 rst_adc_n = 1'b0;
    #1;
    chk("mid_rst_csn", 32'(spi_if.spi_csn), 32'd1);
    chk("mid_rst_sclk", 32'(spi_if.spi_sclk), 32'd0);
    chk("mid_rst_mosi", 32'(spi_if.spi_mosi), 32'd0);
    chk("mid_rst_h", 32'(galvoh), 32'd0);
    chk("mid_rst_v", 32'(galvov), 32'd0);
    chk("mid_rst_done", 32'(galvo_spi_done), 32'd0);
    chk("mid_rst_fe", 32'(frame_end), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk_adc);
    rst_adc_n = 1'b1;
    mk = 0;
    repeat (2) @(negedge clk_adc);
    go_step("post_rst");
    chk("post_rst_frame", 32'(fr_q[s_fr]), 32'h0030_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
